// File: rtl/csr_watchdog.sv
// CSR-mapped watchdog: 4-register window, prescaled countdown, pre-timeout irq, reset-request pulse.
// Latency: csr_do is combinational (0 cycles); register writes take effect on the next clk edge.
// Backpressure: none; every csr_we strobe is accepted in its cycle, misses are ignored.
module csr_watchdog #(
  parameter logic [4:0]  BASE            = 5'h04,
  parameter int unsigned PRESCALE        = 32768,
  parameter logic [7:0]  DEFAULT_TIMEOUT = 8'h0a,
  parameter logic [7:0]  KICK_VALUE      = 8'h6b,
  parameter int unsigned RST_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic       csr_we,
  input  logic [7:0] csr_di,
  output logic [7:0] csr_do,
  output logic       irq,
  output logic       wdt_rst
);

  localparam int PW = $clog2(PRESCALE);
  localparam int RW = $clog2(RST_CYCLES + 1);

  logic          en;
  logic          lock;
  logic          irq_en;
  logic          irq_status;
  logic [7:0]    timeout;
  logic [7:0]    count;
  logic          expired;
  logic [PW-1:0] presc;
  logic [RW-1:0] rst_left;

  logic          hit;
  logic          wr_ctrl;
  logic          wr_timeout;
  logic          wr_kick;
  logic          tick;
  logic          reload;
  logic          tick_live;
  logic          irq_set;
  logic          expire;

  // Address decode, tick generation and the reload/tick priority resolution
  always_comb begin
    hit        = (csr_a[4:2] == BASE[4:2]);
    wr_ctrl    = csr_we && hit && (csr_a[1:0] == 2'd0);
    wr_timeout = csr_we && hit && (csr_a[1:0] == 2'd1);
    wr_kick    = csr_we && hit && (csr_a[1:0] == 2'd2);
    tick       = en && (presc == PW'(PRESCALE - 1));
    // EN rising edge by a CTRL write, or a valid kick while running
    reload     = (wr_ctrl && !lock && csr_di[0] && !en) ||
                 (wr_kick && (csr_di == KICK_VALUE) && en);
    // a reload in the same cycle swallows the tick
    tick_live  = tick && !reload && !expired;
    irq_set    = tick_live && (count == 8'd2);
    expire     = tick_live && (count <= 8'd1);
  end

  // CTRL fields: EN/LOCK frozen once locked, IRQ_EN always writable, status set beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      lock       <= 1'b0;
      irq_en     <= 1'b0;
      irq_status <= 1'b0;
    end else begin
      if (wr_ctrl && !lock) begin
        en   <= csr_di[0];
        lock <= csr_di[1];
      end
      if (wr_ctrl) begin
        irq_en <= csr_di[2];
      end
      if (irq_set) begin
        irq_status <= 1'b1;
      end else if (wr_ctrl && csr_di[3]) begin
        irq_status <= 1'b0;
      end
    end
  end

  // TIMEOUT reload value, write-protected by LOCK
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= DEFAULT_TIMEOUT;
    end else if (wr_timeout && !lock) begin
      timeout <= csr_di;
    end
  end

  // Prescaler: free-runs only while enabled, restarts on reload
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (reload || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Countdown and expiry flag; COUNT parks at 0 after expiry until the next reload
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 8'd0;
      expired <= 1'b0;
    end else if (reload) begin
      count   <= timeout;
      expired <= 1'b0;
    end else if (tick_live) begin
      if (count <= 8'd1) begin
        count   <= 8'd0;
        expired <= 1'b1;
      end else begin
        count <= count - 8'd1;
      end
    end
  end

  // Reset-request pulse length counter; reloads do not cut it short
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_left <= '0;
    end else if (expire) begin
      rst_left <= RW'(RST_CYCLES);
    end else if (rst_left != '0) begin
      rst_left <= rst_left - RW'(1);
    end
  end

  // Combinational read mux; zero outside the window so several blocks can be OR-ed
  always_comb begin
    csr_do = 8'h00;
    if (hit) begin
      case (csr_a[1:0])
        2'd0:    csr_do = {4'b0000, irq_status, irq_en, lock, en};
        2'd1:    csr_do = timeout;
        2'd2:    csr_do = 8'h00;
        default: csr_do = count;
      endcase
    end
  end

  assign irq     = irq_status & irq_en;
  assign wdt_rst = (rst_left != '0);

endmodule

// File: tb/tb_csr_watchdog.sv
// Bench for csr_watchdog: directed scenarios followed by random CSR traffic.
// Expected values come from constants and an event-level model of the watchdog.
module tb_csr_watchdog;

  localparam int          P      = 4;
  localparam int          RC     = 3;
  localparam logic [4:0]  BASE_A = 5'h04;
  localparam logic [7:0]  DEF_TO = 8'h0a;
  localparam logic [7:0]  KICK   = 8'h6b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] csr_a = 5'h00;
  logic       csr_we = 1'b0;
  logic [7:0] csr_di = 8'h00;
  logic [7:0] csr_do;
  logic       irq;
  logic       wdt_rst;

  int n_pass = 0;
  int n_total = 0;

  // model state: register contents, enabled-cycle age, absolute cycle of the last expiry
  bit         m_en, m_lock, m_irqen, m_stat, m_exp, m_fired;
  logic [7:0] m_to, m_cnt;
  int         m_age, m_fire_cyc, cyc;

  int unsigned rr;
  logic [4:0]  ra;
  logic [7:0]  rd;
  bit          seen;

  csr_watchdog #(
    .BASE(BASE_A), .PRESCALE(P), .DEFAULT_TIMEOUT(DEF_TO),
    .KICK_VALUE(KICK), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di),
    .csr_do(csr_do), .irq(irq), .wdt_rst(wdt_rst)
  );

  always #5 clk = ~clk;

  function automatic bit exp_wdt();
    return m_fired && ((cyc - m_fire_cyc) < RC);
  endfunction

  function automatic bit tick_next();
    return m_en && ((m_age % P) == (P - 1));
  endfunction

  // One clock edge of the watchdog, described by its register-level rules
  task automatic model_edge(input bit r, input bit we, input logic [4:0] a, input logic [7:0] d);
    bit hit, tick, reload;
    bit n_en, n_lock, n_irqen, n_stat, n_exp;
    logic [7:0] n_to, n_cnt;
    cyc++;
    if (r) begin
      m_en = 0; m_lock = 0; m_irqen = 0; m_stat = 0; m_exp = 0; m_fired = 0;
      m_to = DEF_TO; m_cnt = 8'h00; m_age = 0;
      return;
    end
    hit  = we && ((a >> 2) == (BASE_A >> 2));
    tick = tick_next();
    reload = 0;
    n_en = m_en; n_lock = m_lock; n_irqen = m_irqen; n_stat = m_stat;
    n_exp = m_exp; n_to = m_to; n_cnt = m_cnt;
    if (hit && (a % 4) == 0) begin
      if (!m_lock) begin
        if (d[0] && !m_en) reload = 1;
        n_en = d[0];
        n_lock = d[1];
      end
      n_irqen = d[2];
      if (d[3]) n_stat = 0;
    end
    if (hit && (a % 4) == 1 && !m_lock) n_to = d;
    if (hit && (a % 4) == 2 && d == KICK && m_en) reload = 1;
    if (reload) begin
      n_cnt = m_to;
      n_exp = 0;
    end else if (tick && !m_exp) begin
      if (m_cnt >= 3) n_cnt = m_cnt - 8'd1;
      else if (m_cnt == 2) begin
        n_cnt = 8'd1;
        n_stat = 1;
      end else begin
        n_cnt = 8'd0;
        n_exp = 1;
        m_fired = 1;
        m_fire_cyc = cyc;
      end
    end
    if (reload || !m_en) m_age = 0;
    else m_age = m_age + 1;
    m_en = n_en; m_lock = n_lock; m_irqen = n_irqen; m_stat = n_stat;
    m_exp = n_exp; m_to = n_to; m_cnt = n_cnt;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, csr_do, exp);
  endtask

  task automatic check_model(input string tag);
    chk_reg({tag, "_ctrl"}, BASE_A, {4'b0000, m_stat, m_irqen, m_lock, m_en});
    chk_reg({tag, "_tmo"}, 5'(BASE_A + 5'd1), m_to);
    chk_reg({tag, "_kick"}, 5'(BASE_A + 5'd2), 8'h00);
    chk_reg({tag, "_cnt"}, 5'(BASE_A + 5'd3), m_cnt);
    chk({tag, "_irq"}, {7'b0, irq}, {7'b0, m_stat & m_irqen});
    chk({tag, "_wdt"}, {7'b0, wdt_rst}, {7'b0, exp_wdt()});
  endtask

  task automatic step(input bit we, input logic [4:0] a, input logic [7:0] d);
    csr_we = we; csr_a = a; csr_di = d;
    @(posedge clk);
    model_edge(0, we, a, d);
    #1;
    csr_we = 0; csr_a = 5'h00; csr_di = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1; csr_we = 0;
    @(posedge clk);
    model_edge(1, 0, 5'h00, 8'h00);
    #1;
    rst = 0;
  endtask

  initial begin
    cyc = 0; m_fire_cyc = 0; m_fired = 0;

    // 1: reset values, out-of-window read
    do_reset();
    chk_reg("t1_ctrl", 5'h04, 8'h00);
    chk_reg("t1_tmo",  5'h05, 8'h0a);
    chk_reg("t1_kick", 5'h06, 8'h00);
    chk_reg("t1_cnt",  5'h07, 8'h00);
    chk_reg("t1_miss", 5'h10, 8'h00);
    chk("t1_irq", {7'b0, irq}, 8'h00);
    chk("t1_wdt", {7'b0, wdt_rst}, 8'h00);

    // 2: countdown from 3, pre-timeout irq, expiry pulse
    step(1, 5'h05, 8'h03);
    step(1, 5'h04, 8'h05);
    chk_reg("t2_cnt0", 5'h07, 8'h03);
    for (int k = 1; k <= 15; k++) begin
      step(0, 5'h00, 8'h00);
      check_model("t2");
      if (k == 4) chk_reg("t2_cnt4", 5'h07, 8'h02);
      if (k == 8) begin
        chk_reg("t2_cnt8", 5'h07, 8'h01);
        chk_reg("t2_ctrl8", 5'h04, 8'h0d);
        chk("t2_irq8", {7'b0, irq}, 8'h01);
      end
      chk("t2_wdt", {7'b0, wdt_rst}, {7'b0, (k >= 12 && k <= 14)});
    end
    chk_reg("t2_cnt_hold", 5'h07, 8'h00);

    // 3: bad kick ignored, good kick reloads, W1C clears status
    step(1, 5'h06, KICK);
    chk_reg("t3_reload", 5'h07, 8'h03);
    for (int k = 0; k < 8; k++) step(0, 5'h00, 8'h00);
    chk_reg("t3_cnt1", 5'h07, 8'h01);
    step(1, 5'h06, 8'h00);
    chk_reg("t3_badkick", 5'h07, 8'h01);
    step(1, 5'h06, KICK);
    chk_reg("t3_kick", 5'h07, 8'h03);
    for (int k = 0; k < 3; k++) step(0, 5'h00, 8'h00);
    chk_reg("t3_noyet", 5'h07, 8'h03);
    step(0, 5'h00, 8'h00);
    chk_reg("t3_dec", 5'h07, 8'h02);
    step(1, 5'h04, 8'h0d);
    chk_reg("t3_ctrl", 5'h04, 8'h05);
    chk("t3_irq", {7'b0, irq}, 8'h00);
    check_model("t3");

    // 4: LOCK freezes EN/LOCK/TIMEOUT
    step(1, 5'h04, 8'h03);
    step(1, 5'h04, 8'h00);
    step(1, 5'h05, 8'hff);
    csr_a = 5'h04;
    #1;
    chk("t4_ctrl", csr_do & 8'h07, 8'h03);
    chk_reg("t4_tmo", 5'h05, 8'h03);
    check_model("t4");
    for (int k = 0; k < 8 && !tick_next(); k++) step(0, 5'h00, 8'h00);

    // 5: kick coinciding with a tick, then a miss write
    step(1, 5'h06, KICK);
    chk_reg("t5_kick_tick", 5'h07, 8'h03);
    check_model("t5a");
    step(1, 5'h10, 8'h01);
    check_model("t5b");

    // 6: reset in the middle of the pulse
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(0, 5'h00, 8'h00);
      seen = wdt_rst;
    end
    chk("t6_pulse_seen", {7'b0, seen}, 8'h01);
    do_reset();
    chk("t6_wdt", {7'b0, wdt_rst}, 8'h00);
    chk_reg("t6_ctrl", 5'h04, 8'h00);
    chk_reg("t6_tmo",  5'h05, 8'h0a);
    chk_reg("t6_cnt",  5'h07, 8'h00);
    for (int k = 0; k < 10; k++) begin
      step(0, 5'h00, 8'h00);
      chk("t6_nopulse", {7'b0, wdt_rst}, 8'h00);
    end

    // random CSR traffic against the model
    for (int i = 0; i < 600; i++) begin
      rr = $urandom_range(0, 99);
      if (rr < 2) begin
        do_reset();
      end else if (rr < 45) begin
        step(0, 5'($urandom), 8'($urandom));
      end else begin
        if ($urandom_range(0, 9) == 0) ra = 5'($urandom);
        else ra = BASE_A | 5'($urandom_range(0, 3));
        rd = 8'($urandom);
        case (ra[1:0])
          2'd0: rd[1] = ($urandom_range(0, 15) == 0);
          2'd1: rd = 8'($urandom_range(0, 6));
          2'd2: if ($urandom_range(0, 1) == 1) rd = KICK;
          default: ;
        endcase
        step(1, ra, rd);
      end
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
